// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI slave front end.
// Holds byte width, synchronizer depth, the minimum sclk half period
// (in clk cycles) and the two-state frame enum.
package spi_pkg;

  localparam int SPI_BYTE_W          = 8;
  localparam int SPI_SYNC_STAGES     = 2;
  localparam int SPI_MIN_HALF_PERIOD = 4;
  localparam int SPI_CNT_W           = $clog2(SPI_BYTE_W);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// Bus bundle between the SPI pins / instruction decoder and spi_slave.
// Optional macro SPI_SLAVE_MISO_OE_EN adds miso_oe for an external tristate.
interface spi_slave_if;
  import spi_pkg::*;

  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  byte_sync;
  logic [SPI_BYTE_W-1:0] data_in;
  logic [SPI_BYTE_W-1:0] data_out;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic                  miso_oe;

  modport slave (
    input  sclk, cs_n, mosi, data_out,
    output miso, byte_sync, data_in, miso_oe
  );

  modport master (
    output sclk, cs_n, mosi, data_out,
    input  miso, byte_sync, data_in, miso_oe
  );
`else
  modport slave (
    input  sclk, cs_n, mosi, data_out,
    output miso, byte_sync, data_in
  );

  modport master (
    output sclk, cs_n, mosi, data_out,
    input  miso, byte_sync, data_in
  );
`endif

endinterface

// File: rtl/spi_slave_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level plus one delay flop,
// producing single-cycle rise/fall pulses in the clk domain.
// RESET_VAL is the idle level of the line so reset release never fakes an edge.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Shift the raw line through the synchronizer, then keep one older sample for edge compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign rise_o =  sync_q[STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[STAGES-1] &  dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversamples sclk/cs_n/mosi on clk, shifts bytes in MSB
// first, pulses byte_sync per complete byte and shifts data_out back on miso.
// Optional macro SPI_SLAVE_MISO_OE_EN drives miso_oe high while a frame is open.
module spi_slave
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  spi_slave_if.slave spiBus
);

  localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(SPI_BYTE_W - 1);

  logic sclkRise;
  logic sclkFall;
  logic csRise;
  logic csFall;
  logic mosiSync;

  logic [SPI_SYNC_STAGES-1:0] mosiSync_q;

  spi_state_e            state_q;
  logic [SPI_CNT_W-1:0]  bitCnt_q;
  logic [SPI_BYTE_W-1:0] rxShift_q;
  logic [SPI_BYTE_W-1:0] txShift_q;
  logic [SPI_BYTE_W-1:0] dataIn_q;
  logic                  byteSync_q;
  logic                  byteDone_q;

  sync_edge #(
    .STAGES    (SPI_SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) uSclkSync (
    .clk     (clk),
    .rst     (rst),
    .async_i (spiBus.sclk),
    .rise_o  (sclkRise),
    .fall_o  (sclkFall)
  );

  sync_edge #(
    .STAGES    (SPI_SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) uCsSync (
    .clk     (clk),
    .rst     (rst),
    .async_i (spiBus.cs_n),
    .rise_o  (csRise),
    .fall_o  (csFall)
  );

  // mosi only needs a plain synchronizer of the same depth so it lines up with the sclk edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosiSync_q <= '0;
    end else begin
      mosiSync_q <= {mosiSync_q[SPI_SYNC_STAGES-2:0], spiBus.mosi};
    end
  end

  assign mosiSync = mosiSync_q[SPI_SYNC_STAGES-1];

  // Frame FSM: opens on cs_n fall, samples on sclk rise, shifts/reloads miso on sclk fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      rxShift_q  <= '0;
      txShift_q  <= '0;
      dataIn_q   <= '0;
      byteSync_q <= 1'b0;
      byteDone_q <= 1'b0;
    end else begin
      byteSync_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (csFall) begin
            state_q    <= ACTIVE;
            txShift_q  <= spiBus.data_out;
            bitCnt_q   <= '0;
            rxShift_q  <= '0;
            byteDone_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (csRise) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            byteDone_q <= 1'b0;
          end else if (sclkRise) begin
            rxShift_q <= {rxShift_q[SPI_BYTE_W-2:0], mosiSync};
            bitCnt_q  <= bitCnt_q + 1'b1;
            if (bitCnt_q == LAST_BIT) begin
              dataIn_q   <= {rxShift_q[SPI_BYTE_W-2:0], mosiSync};
              byteSync_q <= 1'b1;
              byteDone_q <= 1'b1;
            end else begin
              byteDone_q <= 1'b0;
            end
          end else if (sclkFall) begin
            if (byteDone_q) begin
              txShift_q <= spiBus.data_out;
            end else begin
              txShift_q <= {txShift_q[SPI_BYTE_W-2:0], 1'b0};
            end
            byteDone_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign spiBus.miso      = (state_q == ACTIVE) ? txShift_q[SPI_BYTE_W-1] : 1'b0;
  assign spiBus.byte_sync = byteSync_q;
  assign spiBus.data_in   = dataIn_q;
`ifdef SPI_SLAVE_MISO_OE_EN
  assign spiBus.miso_oe   = (state_q == ACTIVE);
`endif

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed below, clock and reset first.
REQ-002 clk  input  1  peripheral clock; all state on posedge clk.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 sclk  input  1  SPI serial clock, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-005 cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-006 mosi  input  1  SPI master-out data, MSB first.
REQ-007 miso  output  1  SPI slave-out data, MSB first.
REQ-008 byte_sync  output  1  one-clk pulse: a complete byte is on data_in.
REQ-009 data_in  output  8  last received byte, to the instruction decoder.
REQ-010 data_out  input  8  byte to transmit, from the instruction decoder.

Function
REQ-011 sclk, cs_n and mosi SHALL each pass a 2-flop synchronizer; sclk edges are detected from the synchronized value and one extra delay flop.
REQ-012 Timing limit: sclk high and low phases SHALL each be at least 4 clk cycles; no behaviour is guaranteed below this.
REQ-013 States: IDLE (cs_n high) and ACTIVE (cs_n low); IDLE->ACTIVE on synchronized cs_n fall; any->IDLE on synchronized cs_n rise.
REQ-014 On the IDLE->ACTIVE transition: load tx_shift <= data_out, clear bit_cnt to 0, clear rx_shift.
REQ-015 In ACTIVE, on each synchronized sclk rising edge: rx_shift <= {rx_shift[6:0], mosi_sync}, bit_cnt increments mod 8.
REQ-016 On the rising edge that completes bit 7 (bit_cnt 7->0): data_in <= {rx_shift[6:0], mosi_sync} and byte_sync=1 on the following clk only.
REQ-017 In ACTIVE, on each synchronized sclk falling edge: if the preceding rising edge completed a byte, tx_shift <= data_out (reload); otherwise tx_shift <= {tx_shift[6:0], 1'b0}.
REQ-018 miso SHALL equal tx_shift[7] in ACTIVE and 0 in IDLE.
REQ-019 data_in SHALL hold its value until the next completed byte; byte_sync SHALL never be high for 2 consecutive cycles.
REQ-020 If cs_n deasserts mid-byte (bit_cnt != 0), the partial byte SHALL be discarded: no byte_sync, data_in unchanged, bit_cnt <= 0.
REQ-021 sclk edges seen in IDLE SHALL be ignored.
REQ-022 If a cs_n rise and an sclk rising edge are detected in the same cycle, cs_n wins: the edge is ignored.

Reset
REQ-023 While rst=1: state=IDLE, bit_cnt=0, rx_shift=0, tx_shift=0, data_in=0, byte_sync=0, miso=0, synchronizer flops=cs_n high/sclk low/mosi low.
REQ-024 Reset asserted mid-transfer SHALL abort the byte; after release, the block waits for a fresh cs_n fall before accepting data.

Configuration
REQ-025 Macro SPI_SLAVE_MISO_OE_EN: when defined, add output miso_oe (1 bit) = 1 in ACTIVE, 0 in IDLE and reset, for an external tristate buffer; when undefined, no miso_oe port exists and miso drives 0 in IDLE per REQ-018.

Structure
REQ-026 The shared package spi_pkg SHALL hold SPI_BYTE_W=8, SPI_SYNC_STAGES=2, SPI_MIN_HALF_PERIOD=4 and the state enum type (IDLE, ACTIVE).
REQ-027 One sub-module, sync_edge, SHALL implement a synchronizer plus rise/fall pulse detection, instantiated for sclk and cs_n; mosi uses the synchronizer only.

Verification
REQ-028 After reset release, cs_n low, shift mosi 0xA5 with sclk half-period 6 clk -> exactly one byte_sync, data_in=0xA5.
REQ-029 data_out=0x3C at cs_n fall, then two bytes, with data_out changed to 0x81 between them -> miso carries 0x3C, then 0x81, MSB first, stable at each sclk rise.
REQ-030 Send 5 bits, raise cs_n, then lower cs_n and send a full 0x0F -> no byte_sync after the 5 bits; data_in=0x0F after the full byte.
REQ-031 Pulse rst mid-byte after 3 bits, then send 0xFF in a new cs_n frame -> all outputs 0 during reset; one byte_sync with data_in=0xFF afterwards.
REQ-032 Toggle sclk with cs_n high for 16 edges -> no byte_sync; miso=0 (and miso_oe=0 with SPI_SLAVE_MISO_OE_EN).
REQ-033 Connected to the instruction decoder, send a write frame 0xC2, 0x55 -> the decoder's write pulse fires once, with addr=0x02 and data_write=0x55.
